// File: rtl/commutation_decoder.sv
// Hall/coil pattern to six-step commutation decoder with direction, period and stall tracking.
// Optional input debounce is compiled in with `define COMMUT_DEBOUNCE_EN.
module commutation_decoder #(
    parameter int unsigned STALL_CYCLES    = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        _rst,
    input  logic        phase_a,
    input  logic        phase_b,
    input  logic        phase_c,
    output logic [2:0]  step,
    output logic        step_valid,
    output logic        dir,
    output logic [31:0] period,
    output logic        stall,
    output logic        illegal_err,
    output logic        skip_err
);

    localparam logic [31:0] StallLimit = 32'(STALL_CYCLES - 1);

    if (STALL_CYCLES == 0 || DEBOUNCE_CYCLES == 0) begin : g_param_check
        $error("commutation_decoder: STALL_CYCLES and DEBOUNCE_CYCLES must be nonzero");
    end

    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic [2:0]  acc_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_inc;
    logic [2:0]  code;
    logic [2:0]  step_up;
    logic [2:0]  step_dn;
    logic        pat_ok;
    logic        pat_event;
    logic        is_illegal;
    logic        stall_cond;

    function automatic logic [2:0] decode(input logic [2:0] pat);
        logic [2:0] res;
        case (pat)
            3'b110:  res = 3'd1;
            3'b100:  res = 3'd2;
            3'b101:  res = 3'd3;
            3'b001:  res = 3'd4;
            3'b011:  res = 3'd5;
            3'b010:  res = 3'd6;
            default: res = 3'd0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {phase_a, phase_b, phase_c};
            sync2_q <= sync1_q;
        end
    end

`ifdef COMMUT_DEBOUNCE_EN
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]     cand_q;
    logic [DbW-1:0] db_cnt_q;

    // Any change of the synchronized pattern restarts the stability count.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            cand_q   <= 3'b000;
            db_cnt_q <= '0;
        end else if (sync2_q != cand_q) begin
            cand_q   <= sync2_q;
            db_cnt_q <= '0;
        end else if (db_cnt_q != DbLast) begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign pat_ok = (sync2_q == cand_q) && (db_cnt_q == DbLast);
`else
    assign pat_ok = 1'b1;
`endif

    always_comb begin
        code       = decode(sync2_q);
        is_illegal = (sync2_q == 3'b111);
        pat_event  = pat_ok && (sync2_q != acc_q);
        cnt_inc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        step_up    = (step == 3'd6) ? 3'd1 : step + 3'd1;
        step_dn    = (step == 3'd1) ? 3'd6 : step - 3'd1;
        stall_cond = (step != 3'd0) && (cnt_q >= StallLimit);
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            acc_q       <= 3'b000;
            step        <= 3'd0;
            step_valid  <= 1'b0;
            dir         <= 1'b0;
            period      <= 32'd0;
            stall       <= 1'b0;
            illegal_err <= 1'b0;
            skip_err    <= 1'b0;
            cnt_q       <= 32'd0;
        end else begin
            step_valid  <= 1'b0;
            illegal_err <= 1'b0;
            skip_err    <= 1'b0;
            if (pat_event) begin
                acc_q <= sync2_q;
            end
            if (pat_event && is_illegal) begin
                // Counter freezes on the illegal clock so the next period is not inflated.
                illegal_err <= 1'b1;
                stall       <= stall_cond;
            end else if (pat_event && (code != step)) begin
                // A real transition wins over stall assertion and counter saturation.
                cnt_q <= 32'd0;
                stall <= 1'b0;
                step  <= code;
                if (code != 3'd0) begin
                    step_valid <= 1'b1;
                    if (step != 3'd0) begin
                        period <= cnt_inc;
                        if (code == step_up) begin
                            dir <= 1'b1;
                        end else if (code == step_dn) begin
                            dir <= 1'b0;
                        end else begin
                            skip_err <= 1'b1;
                        end
                    end
                end
            end else begin
                cnt_q <= cnt_inc;
                stall <= stall_cond;
            end
        end
    end

endmodule

// File: tb/tb_commutation_decoder.sv
// Bench for commutation_decoder: cycle model of the decode rules plus directed literal checks.
// Honours COMMUT_DEBOUNCE_EN to select the expected input latency.
module tb_commutation_decoder;

    localparam int unsigned STALL = 200;
    localparam int unsigned DEB   = 16;
`ifdef COMMUT_DEBOUNCE_EN
    localparam int LAT  = 3 + DEB;
    localparam int NEED = DEB + 1;
`else
    localparam int LAT  = 3;
    localparam int NEED = 1;
`endif
    localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  pat   = 3'b000;
    logic [2:0]  step;
    logic        step_valid;
    logic        dir;
    logic [31:0] period;
    logic        stall;
    logic        illegal_err;
    logic        skip_err;

    commutation_decoder #(
        .STALL_CYCLES    (STALL),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        ._rst        (rst_n),
        .phase_a     (pat[2]),
        .phase_b     (pat[1]),
        .phase_c     (pat[0]),
        .step        (step),
        .step_valid  (step_valid),
        .dir         (dir),
        .period      (period),
        .stall       (stall),
        .illegal_err (illegal_err),
        .skip_err    (skip_err)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_ill   = 0;
    int n_skip  = 0;

    // Model state: pattern index -> step number, 7 marks the illegal pattern.
    int     code_of [8] = '{0, 4, 6, 5, 2, 3, 1, 7};
    logic [2:0] h1, h2, m_acc, prev_p;
    int     run;
    int     m_step, m_dir;
    longint m_cnt, m_period;
    bit     m_stall, m_valid, m_ill, m_skip;

    task automatic cmp(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: dut=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        h1 = 3'b000; h2 = 3'b000; m_acc = 3'b000; prev_p = 3'b000; run = 1;
        m_step = 0; m_dir = 0; m_cnt = 0; m_period = 0;
        m_stall = 0; m_valid = 0; m_ill = 0; m_skip = 0;
    endtask

    task automatic model_step();
        logic [2:0] p;
        int         code, diff;
        bit         stall_now;
        longint     cnt_next;
        p  = h2;
        h2 = h1;
        h1 = pat;
        run = (p == prev_p) ? ((run < 1000) ? run + 1 : run) : 1;
        prev_p = p;
        m_valid = 0; m_ill = 0; m_skip = 0;
        stall_now = (m_step != 0) && (m_cnt >= longint'(STALL) - 1);
        cnt_next  = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
        code = code_of[p];
        if (run >= NEED && p != m_acc) begin
            m_acc = p;
            if (code == 7) begin
                m_ill   = 1;
                m_stall = stall_now;
            end else if (code != m_step) begin
                if (code != 0) begin
                    m_valid = 1;
                    if (m_step != 0) begin
                        diff = (code - m_step + 6) % 6;
                        if (diff == 1) m_dir = 1;
                        else if (diff == 5) m_dir = 0;
                        else m_skip = 1;
                        m_period = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
                    end
                end
                m_step  = code;
                m_cnt   = 0;
                m_stall = 0;
            end else begin
                m_cnt   = cnt_next;
                m_stall = stall_now;
            end
        end else begin
            m_cnt   = cnt_next;
            m_stall = stall_now;
        end
    endtask

    task automatic check_outputs();
        cmp("step", step, m_step);
        cmp("step_valid", step_valid, m_valid);
        cmp("dir", dir, m_dir);
        cmp("period", period, m_period);
        cmp("stall", stall, m_stall);
        cmp("illegal_err", illegal_err, m_ill);
        cmp("skip_err", skip_err, m_skip);
    endtask

    // Pattern held for 'hold' clocks starting just after the next rising edge.
    task automatic drive(input logic [2:0] p, input int hold);
        @(posedge clk);
        #1 pat = p;
        repeat (hold - 1) @(posedge clk);
    endtask

    initial begin
        int k, j, v0, s0, i0;
        model_reset();
        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) model_reset();
                else model_step();
            end
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    check_outputs();
                    n_valid += int'(step_valid);
                    n_ill   += int'(illegal_err);
                    n_skip  += int'(skip_err);
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        cmp("reset step", step, 0);
        cmp("reset period", period, 0);
        cmp("reset dir", dir, 0);
        cmp("reset stall", stall, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Input-to-output latency, then the ascending sweep at 100-clock spacing.
        v0 = n_valid;
        @(posedge clk);
        #1 pat = 3'b110;
        repeat (LAT) @(negedge clk);
        cmp("pre-latency step", step, 0);
        @(negedge clk);
        cmp("latency step", step, 1);
        cmp("latency step_valid", step_valid, 1);
        repeat (100 - LAT - 1) @(posedge clk);
        drive(3'b100, 100);
        drive(3'b101, 100);
        drive(3'b001, 100);
        drive(3'b011, 100);
        drive(3'b010, 100);
        drive(3'b110, 100);
        @(negedge clk);
        cmp("fwd step", step, 1);
        cmp("fwd dir", dir, 1);
        cmp("fwd period", period, 100);
        cmp("fwd valid pulses", n_valid - v0, 7);

        // Descending sweep at 50-clock spacing.
        s0 = n_skip;
        drive(3'b010, 50);
        drive(3'b011, 50);
        drive(3'b001, 50);
        drive(3'b101, 50);
        drive(3'b100, 50);
        drive(3'b110, 50);
        @(negedge clk);
        cmp("rev step", step, 1);
        cmp("rev dir", dir, 0);
        cmp("rev period", period, 50);
        cmp("rev skip pulses", n_skip - s0, 0);

        // Skip 1 -> 4, then an illegal pattern.
        s0 = n_skip;
        drive(3'b001, 50);
        @(negedge clk);
        cmp("skip step", step, 4);
        cmp("skip pulses", n_skip - s0, 1);
        cmp("skip dir held", dir, 0);
        i0 = n_ill;
        drive(3'b111, 50);
        @(negedge clk);
        cmp("illegal pulses", n_ill - i0, 1);
        cmp("illegal step held", step, 4);

        // Stall: hold step 2 for 300 clocks.
        @(posedge clk);
        #1 pat = 3'b100;
        k = 0;
        while (step != 3'd2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        cmp("stall-test accept latency", k, LAT + 1);
        j = 0;
        while (!stall && j < 400) begin
            @(negedge clk);
            j++;
        end
        cmp("stall rise delay", j, 200);
        repeat (99 - LAT) @(posedge clk);
        drive(3'b101, 50);
        @(negedge clk);
        cmp("post-stall step", step, 3);
        cmp("post-stall stall", stall, 0);
        cmp("post-stall period", period, 300);
        cmp("post-stall dir", dir, 1);

        // Off code, then restart from step 0.
        v0 = n_valid;
        drive(3'b000, 50);
        @(negedge clk);
        cmp("off step", step, 0);
        cmp("off period held", period, 300);
        cmp("off dir held", dir, 1);
        cmp("off no valid", n_valid - v0, 0);
        drive(3'b001, 50);
        @(negedge clk);
        cmp("from-off step", step, 4);
        cmp("from-off period held", period, 300);
        drive(3'b011, 50);
        @(negedge clk);
        cmp("step5 period", period, 50);
        cmp("step5 dir", dir, 1);

        // Mid-sequence reset at step 5.
        @(posedge clk);
        #3 rst_n = 1'b0;
        pat = 3'b000;
        #1;
        cmp("async reset step", step, 0);
        cmp("async reset period", period, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        v0 = n_valid;
        s0 = n_skip;
        drive(3'b010, 50);
        @(negedge clk);
        cmp("post-reset step", step, 6);
        cmp("post-reset dir", dir, 0);
        cmp("post-reset period", period, 0);
        cmp("post-reset valid pulses", n_valid - v0, 1);
        cmp("post-reset skip pulses", n_skip - s0, 0);

`ifdef COMMUT_DEBOUNCE_EN
        // Short glitch is filtered; a long pattern lands after 3+DEB clocks.
        drive(3'b100, 50);
        v0 = n_valid;
        drive(3'b101, 10);
        drive(3'b100, 50);
        @(negedge clk);
        cmp("glitch step", step, 2);
        cmp("glitch valid pulses", n_valid - v0, 0);
        @(posedge clk);
        #1 pat = 3'b101;
        repeat (LAT) @(negedge clk);
        cmp("debounce pre step", step, 2);
        @(negedge clk);
        cmp("debounce step", step, 3);
        repeat (5) @(posedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
